// File: rtl/rr_add_sched4_pkg.sv
// Shared types and constants for the four-way round-robin adder scheduler.
package rr_add_sched4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int N_REQ = 4;
  localparam int PTR_W = 2;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod 4.
module rr_pick4
  import rr_add_sched4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest candidate to ptr wins.
  always_comb begin
    found  = 1'b0;
    idx    = ptr;
    w_cand = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = ptr + PTR_W'(k);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_add_sched4.sv
// Round-robin scheduler sharing one WIDTH-bit adder between four 4-phase requesters.
// Optional carry output enabled by RR_ADD_SCHED4_CARRY_EN.
module rr_add_sched4
  import rr_add_sched4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       y,
  output logic [PTR_W-1:0]       gnt_id,
  output logic                   busy
`ifdef RR_ADD_SCHED4_CARRY_EN
  ,
  output logic                   cout
`endif
);

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_gnt;
  logic [N_REQ-1:0] r_ack;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic             r_busy;
  logic             w_found;
  logic [PTR_W-1:0] w_idx;

`ifdef RR_ADD_SCHED4_CARRY_EN
  logic             r_cout;
  logic [WIDTH:0]   w_sum;
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign cout  = r_cout;
`else
  logic [WIDTH-1:0] w_sum;
  assign w_sum = r_a + r_b;
`endif

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
`ifdef RR_ADD_SCHED4_CARRY_EN
      r_cout  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a     <= a_in[w_idx*WIDTH +: WIDTH];
            r_b     <= b_in[w_idx*WIDTH +: WIDTH];
            r_gnt   <= w_idx;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_y     <= w_sum[WIDTH-1:0];
`ifdef RR_ADD_SCHED4_CARRY_EN
          r_cout  <= w_sum[WIDTH];
`endif
          r_ack   <= N_REQ'(1) << r_gnt;
          r_state <= RESP;
        end
        RESP: begin
          // Release only once the granted requester has withdrawn its request.
          if (!req[r_gnt]) begin
            r_ack   <= '0;
            r_ptr   <= r_gnt + PTR_W'(1);
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack    = r_ack;
  assign y      = r_y;
  assign gnt_id = r_gnt;
  assign busy   = r_busy;

endmodule

// File: tb/tb_rr_add_sched4.sv
// Self-checking bench for rr_add_sched4 with a round-robin reference model.
// Carry checks are included when RR_ADD_SCHED4_CARRY_EN is defined.
module tb_rr_add_sched4;

  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic [3:0]     req;
  logic [4*W-1:0] a_in;
  logic [4*W-1:0] b_in;
  logic [3:0]     ack;
  logic [W-1:0]   y;
  logic [1:0]     gnt_id;
  logic           busy;
`ifdef RR_ADD_SCHED4_CARRY_EN
  logic           cout;
`endif

  logic [W-1:0] a_op [4];
  logic [W-1:0] b_op [4];

  int errors;
  int checks;
  int mptr;

  assign a_in = {a_op[3], a_op[2], a_op[1], a_op[0]};
  assign b_in = {b_op[3], b_op[2], b_op[1], b_op[0]};

  rr_add_sched4 #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .ack    (ack),
    .y      (y),
    .gnt_id (gnt_id),
    .busy   (busy)
`ifdef RR_ADD_SCHED4_CARRY_EN
    ,
    .cout   (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first active requester in order p, p+1, p+2, p+3 (mod 4).
  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic int model_sum(input int w);
    return (int'(a_op[w]) + int'(b_op[w])) % (1 << W);
  endfunction

  function automatic int model_carry(input int w);
    return (int'(a_op[w]) + int'(b_op[w])) / (1 << W);
  endfunction

  // Advance until ack rises or the cycle budget expires; returns cycles spent.
  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (ack === 4'b0000 && cyc < 12);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    tick();
    tick();
    reset = 1'b0;
    mptr  = 0;
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack got=%b exp=%b", ack, 4'b0000); end
    checks++;
    if (y !== 4'd0) begin errors++; $display("[TB] FAIL reset_y got=%0d exp=0", y); end
    checks++;
    if (gnt_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_gnt got=%0d exp=0", gnt_id); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    a_op[0] = 4'd3;
    b_op[0] = 4'd4;
    req     = 4'b0001;
    tick();
    checks++;
    if (busy !== 1'b1 || ack !== 4'b0000) begin
      errors++; $display("[TB] FAIL single_exec busy=%b ack=%b exp busy=1 ack=0000", busy, ack);
    end
    tick();
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("[TB] FAIL single_ack got=%b exp=0001", ack); end
    checks++;
    if (y !== 4'd7) begin errors++; $display("[TB] FAIL single_y got=%0d exp=7", y); end
    checks++;
    if (gnt_id !== 2'd0) begin errors++; $display("[TB] FAIL single_gnt got=%0d exp=0", gnt_id); end
    req = 4'b0000;
    tick();
    mptr = 1;
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL single_release ack=%b busy=%b exp ack=0000 busy=0", ack, busy);
    end
    tick();
    checks++;
    if (y !== 4'd7) begin errors++; $display("[TB] FAIL single_y_hold got=%0d exp=7", y); end
  endtask

  task automatic test_wrap();
    int cyc;
    a_op[2] = 4'd9;
    b_op[2] = 4'd8;
    req     = 4'b0100;
    wait_ack(cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("[TB] FAIL wrap_latency got=%0d exp=2", cyc); end
    checks++;
    if (ack !== 4'b0100 || gnt_id !== 2'd2) begin
      errors++; $display("[TB] FAIL wrap_grant ack=%b gnt=%0d exp ack=0100 gnt=2", ack, gnt_id);
    end
    checks++;
    if (y !== 4'd1) begin errors++; $display("[TB] FAIL wrap_y got=%0d exp=1", y); end
`ifdef RR_ADD_SCHED4_CARRY_EN
    checks++;
    if (cout !== 1'b1) begin errors++; $display("[TB] FAIL wrap_cout got=%b exp=1", cout); end
`endif
    req = 4'b0000;
    tick();
    mptr = 3;
  endtask

  // Every requester always asking; each one re-raises as soon as its ack falls.
  task automatic test_fairness();
    int cyc;
    int exp_w;
    int order [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mptr  = 0;
    for (int i = 0; i < 4; i++) begin
      a_op[i] = W'($urandom_range(0, 15));
      b_op[i] = W'($urandom_range(0, 15));
    end
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_w = model_pick(req, mptr);
      wait_ack(cyc);
      checks++;
      if (cyc !== 2) begin errors++; $display("[TB] FAIL fair_latency grant=%0d got=%0d exp=2", g, cyc); end
      checks++;
      if (gnt_id !== 2'(order[g]) || exp_w != order[g]) begin
        errors++; $display("[TB] FAIL fair_order grant=%0d got=%0d exp=%0d", g, gnt_id, order[g]);
      end
      checks++;
      if (ack !== (4'b0001 << exp_w)) begin errors++; $display("[TB] FAIL fair_ack got=%b exp_id=%0d", ack, exp_w); end
      checks++;
      if (y !== W'(model_sum(exp_w))) begin errors++; $display("[TB] FAIL fair_y got=%0d exp=%0d", y, model_sum(exp_w)); end
      req[exp_w] = 1'b0;
      tick();
      mptr = (exp_w + 1) % 4;
      checks++;
      if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL fair_release got=%b exp=0000", ack); end
      a_op[exp_w] = W'($urandom_range(0, 15));
      b_op[exp_w] = W'($urandom_range(0, 15));
      req[exp_w]  = (g < 4);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_pointer_skip();
    int cyc;
    a_op[1] = W'($urandom_range(0, 15));
    b_op[1] = W'($urandom_range(0, 15));
    req = 4'b0010;
    wait_ack(cyc);
    checks++;
    if (gnt_id !== 2'd1) begin errors++; $display("[TB] FAIL skip_first got=%0d exp=1", gnt_id); end
    req = 4'b0000;
    tick();
    mptr = 2;
    a_op[0] = W'($urandom_range(0, 15));
    b_op[0] = W'($urandom_range(0, 15));
    req = 4'b0011;
    wait_ack(cyc);
    checks++;
    if (gnt_id !== 2'(model_pick(4'b0011, mptr)) || ack !== 4'b0001) begin
      errors++; $display("[TB] FAIL skip_grant gnt=%0d ack=%b exp gnt=0 ack=0001", gnt_id, ack);
    end
    checks++;
    if (y !== W'(model_sum(0))) begin errors++; $display("[TB] FAIL skip_y got=%0d exp=%0d", y, model_sum(0)); end
    req = 4'b0010;
    tick();
    mptr = 1;
    wait_ack(cyc);
    checks++;
    if (gnt_id !== 2'(model_pick(4'b0010, mptr)) || y !== W'(model_sum(1))) begin
      errors++; $display("[TB] FAIL skip_pending gnt=%0d y=%0d exp gnt=1 y=%0d", gnt_id, y, model_sum(1));
    end
    req = 4'b0000;
    tick();
    mptr = 2;
  endtask

  // Pointer sits at 2 here; after reset it must restart from 0 and favour requester 1 over 2.
  task automatic test_reset_mid();
    int cyc;
    a_op[2] = W'($urandom_range(0, 15));
    b_op[2] = W'($urandom_range(1, 15));
    req = 4'b0100;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || y !== 4'd0 || gnt_id !== 2'd0) begin
      errors++; $display("[TB] FAIL midreset_state ack=%b busy=%b y=%0d gnt=%0d exp all 0", ack, busy, y, gnt_id);
    end
    mptr = 0;
    a_op[1] = W'($urandom_range(0, 15));
    b_op[1] = W'($urandom_range(0, 15));
    req = 4'b0110;
    wait_ack(cyc);
    checks++;
    if (gnt_id !== 2'(model_pick(4'b0110, mptr))) begin errors++; $display("[TB] FAIL midreset_ptr got=%0d exp=1", gnt_id); end
    checks++;
    if (y !== W'(model_sum(1))) begin errors++; $display("[TB] FAIL midreset_y got=%0d exp=%0d", y, model_sum(1)); end
    req = 4'b0000;
    tick();
    mptr = 2;
  endtask

  task automatic test_held_ack();
    int cyc;
    a_op[3] = W'($urandom_range(0, 15));
    b_op[3] = W'($urandom_range(0, 15));
    req = 4'b1000;
    wait_ack(cyc);
    checks++;
    if (ack !== 4'b1000) begin errors++; $display("[TB] FAIL held_grant got=%b exp=1000", ack); end
    a_op[0] = W'($urandom_range(0, 15));
    b_op[0] = W'($urandom_range(0, 15));
    req = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ack !== 4'b1000 || busy !== 1'b1 || gnt_id !== 2'd3 || y !== W'(model_sum(3))) begin
        errors++; $display("[TB] FAIL held_stable cyc=%0d ack=%b busy=%b gnt=%0d y=%0d", i, ack, busy, gnt_id, y);
      end
    end
    req = 4'b0001;
    tick();
    mptr = 0;
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL held_release ack=%b busy=%b", ack, busy); end
    tick();
    checks++;
    if (busy !== 1'b1 || gnt_id !== 2'd0) begin errors++; $display("[TB] FAIL held_resume busy=%b gnt=%0d exp 1/0", busy, gnt_id); end
    tick();
    checks++;
    if (ack !== 4'b0001 || y !== W'(model_sum(0))) begin
      errors++; $display("[TB] FAIL held_resume_ack ack=%b y=%0d exp 0001/%0d", ack, y, model_sum(0));
    end
    req = 4'b0000;
    tick();
    mptr = 1;
  endtask

  // Random arrivals: newly raised requesters get fresh operands, pending ones keep theirs.
  task automatic test_random();
    int cyc;
    int exp_w;
    logic [3:0] raise;
    for (int t = 0; t < 24; t++) begin
      raise = 4'($urandom_range(0, 15));
      if (req == 4'b0000 && raise == 4'b0000) raise = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        if (raise[i] && !req[i]) begin
          a_op[i] = W'($urandom_range(0, 15));
          b_op[i] = W'($urandom_range(0, 15));
          req[i]  = 1'b1;
        end
      end
      exp_w = model_pick(req, mptr);
      wait_ack(cyc);
      checks++;
      if (cyc !== 2 || gnt_id !== 2'(exp_w) || ack !== (4'b0001 << exp_w)) begin
        errors++; $display("[TB] FAIL rand_grant t=%0d lat=%0d gnt=%0d ack=%b exp gnt=%0d", t, cyc, gnt_id, ack, exp_w);
      end
      checks++;
      if (y !== W'(model_sum(exp_w))) begin errors++; $display("[TB] FAIL rand_y t=%0d got=%0d exp=%0d", t, y, model_sum(exp_w)); end
`ifdef RR_ADD_SCHED4_CARRY_EN
      checks++;
      if (cout !== 1'(model_carry(exp_w))) begin errors++; $display("[TB] FAIL rand_cout t=%0d got=%b exp=%0d", t, cout, model_carry(exp_w)); end
`endif
      req[exp_w] = 1'b0;
      tick();
      mptr = (exp_w + 1) % 4;
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    req    = 4'b0000;
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_pointer_skip();
    test_reset_mid();
    test_held_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
